// File: rtl/blend_pkg.sv
// -----------------------------------------------------------------------------
// blend_pkg
//   Definitions shared by the alpha fade sequencer and the colour blender:
//   - fade_state_e : fade sequencer state encoding
//   - ALPHA_MIN / ALPHA_MAX : transparent / opaque alpha codes
//   - COLOR_W : width of the RGB444 colour path
//   - helpers that map a fade direction to its start and end alpha codes
// -----------------------------------------------------------------------------
package blend_pkg;

    localparam int COLOR_W = 12;

    localparam logic [2:0] ALPHA_MIN = 3'd0;
    localparam logic [2:0] ALPHA_MAX = 3'd7;

    typedef enum logic [1:0] {
        FADE_IDLE  = 2'd0,
        FADE_ARMED = 2'd1,
        FADE_RUN   = 2'd2,
        FADE_DONE  = 2'd3
    } fade_state_e;

    // dir = 0 fades in (transparent -> opaque), dir = 1 fades out.
    function automatic logic [2:0] alpha_start(input logic dir);
        return dir ? ALPHA_MAX : ALPHA_MIN;
    endfunction

    function automatic logic [2:0] alpha_end(input logic dir);
        return dir ? ALPHA_MIN : ALPHA_MAX;
    endfunction

endpackage : blend_pkg

// File: rtl/frame_step_counter.sv
// -----------------------------------------------------------------------------
// frame_step_counter
//   Counts frame ticks and emits a step pulse on every i_period-th tick, i.e.
//   in the same cycle as the tick on which the count wraps back to zero.
//   The caller guarantees i_period >= 1.
//
// Ports
//   i_clk     in   1         clock
//   i_rst_n   in   1         asynchronous active-low reset
//   i_tick    in   1         count enable (one qualified frame tick)
//   i_clear   in   1         force the count to zero (wins over i_tick)
//   i_period  in   PERIOD_W  ticks per step
//   o_step    out  1         combinational pulse, high on the wrapping tick
// -----------------------------------------------------------------------------
module frame_step_counter #(
    parameter int PERIOD_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_tick,
    input  logic                i_clear,
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_step
);

    localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;
    logic                wrap;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_d = cnt_q;
        wrap  = (cnt_q == (i_period - CNT_ONE));

        if (i_clear) begin
            cnt_d = '0;
        end else if (i_tick) begin
            cnt_d = wrap ? '0 : (cnt_q + CNT_ONE);
        end
    end

    // The step is combinational so the alpha register moves on the very
    // tick that completes the period, not one cycle later.
    assign o_step = i_tick && !i_clear && wrap;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : frame_step_counter

// File: rtl/alpha_fade_sequencer.sv
// -----------------------------------------------------------------------------
// alpha_fade_sequencer
//   Drives the blender's fg colour and 3-bit alpha code. On i_start it latches
//   direction, period and colour, then ramps alpha one code per i_period frame
//   ticks between transparent (0) and opaque (7). Alpha only ever moves on a
//   frame tick, so it never changes mid-frame.
//
//   Build option FADE_PINGPONG_EN: when defined, reaching the end value turns
//   the fade around instead of finishing; o_done marks each turn and only
//   i_abort or reset stops the sequencer.
//
// Ports
//   i_clk         in   1         pixel/system clock
//   i_rst_n       in   1         asynchronous active-low reset
//   i_frame_tick  in   1         one-cycle pulse per frame (vblank start)
//   i_start       in   1         begin a fade (accepted only when idle)
//   i_abort       in   1         stop now, hold alpha and colour
//   i_dir         in   1         0 = fade in, 1 = fade out (sampled on start)
//   i_period      in   PERIOD_W  frames per alpha step, 0 acts as 1
//   i_color       in   COLOR_W   fade colour (sampled on start)
//   o_fg_color    out  COLOR_W   registered fade colour
//   o_fg_alpha    out  3         registered alpha code
//   o_busy        out  1         fade armed or running
//   o_done        out  1         one-cycle pulse on reaching the end value
// -----------------------------------------------------------------------------
module alpha_fade_sequencer #(
    parameter int PERIOD_W = 8,
    parameter int COLOR_W  = blend_pkg::COLOR_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_frame_tick,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic                i_dir,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic [COLOR_W-1:0]  i_color,
    output logic [COLOR_W-1:0]  o_fg_color,
    output logic [2:0]          o_fg_alpha,
    output logic                o_busy,
    output logic                o_done
);

    import blend_pkg::*;

    localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

    fade_state_e         state_q,  state_d;
    logic                dir_q,    dir_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [COLOR_W-1:0]  color_q,  color_d;
    logic [2:0]          alpha_q,  alpha_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    logic                cnt_tick;
    logic                cnt_clear;
    logic                cnt_step;
    logic [2:0]          alpha_next;
    logic [2:0]          end_value;

    frame_step_counter #(
        .PERIOD_W (PERIOD_W)
    ) u_step_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_tick   (cnt_tick),
        .i_clear  (cnt_clear),
        .i_period (period_q),
        .o_step   (cnt_step)
    );

    // Saturating one-code step toward the current end value.
    always_comb begin
        end_value  = alpha_end(dir_q);
        alpha_next = alpha_q;
        if (alpha_q != end_value) begin
            alpha_next = dir_q ? (alpha_q - 3'd1) : (alpha_q + 3'd1);
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        period_d  = period_q;
        color_d   = color_q;
        alpha_d   = alpha_q;
        done_d    = 1'b0;
        cnt_tick  = 1'b0;
        cnt_clear = 1'b0;

        unique case (state_q)
            FADE_IDLE: begin
                // Abort wins over a simultaneous start.
                if (i_start && !i_abort) begin
                    dir_d    = i_dir;
                    period_d = (i_period == '0) ? PERIOD_ONE : i_period;
                    color_d  = i_color;
                    alpha_d  = alpha_start(i_dir);
                    state_d  = FADE_ARMED;
                end
            end

            FADE_ARMED: begin
                // The tick that arrives with the start was seen in IDLE, so
                // only a later tick arms the fade.
                if (i_abort) begin
                    state_d = FADE_IDLE;
                end else if (i_frame_tick) begin
                    cnt_clear = 1'b1;
                    state_d   = FADE_RUN;
                end
            end

            FADE_RUN: begin
                if (i_abort) begin
                    state_d = FADE_IDLE;
                end else if (i_frame_tick) begin
                    cnt_tick = 1'b1;
                    if (cnt_step) begin
                        alpha_d = alpha_next;
                        if (alpha_next == end_value) begin
                            done_d = 1'b1;
`ifdef FADE_PINGPONG_EN
                            // Turn around; the counter already wrapped to 0.
                            dir_d   = ~dir_q;
`else
                            state_d = FADE_DONE;
`endif
                        end
                    end
                end
            end

            FADE_DONE: begin
                state_d = FADE_IDLE;
            end

            default: begin
                state_d = FADE_IDLE;
            end
        endcase

        busy_d = (state_d == FADE_ARMED) || (state_d == FADE_RUN);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= FADE_IDLE;
            dir_q    <= 1'b0;
            period_q <= PERIOD_ONE;
            color_q  <= '0;
            alpha_q  <= ALPHA_MIN;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            period_q <= period_d;
            color_q  <= color_d;
            alpha_q  <= alpha_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_fg_color = color_q;
    assign o_fg_alpha = alpha_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule : alpha_fade_sequencer

// File: tb/tb_alpha_fade_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alpha_fade_sequencer
//   Self-checking bench for alpha_fade_sequencer. The reference model tracks
//   the fade as "ticks since arming" and derives alpha arithmetically from the
//   number of completed periods.
// -----------------------------------------------------------------------------
module tb_alpha_fade_sequencer;

    localparam int PERIOD_W = 8;
    localparam int COLOR_W  = 12;

`ifdef FADE_PINGPONG_EN
    localparam bit PINGPONG = 1'b1;
`else
    localparam bit PINGPONG = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                frame_tick = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic                dir = 1'b0;
    logic [PERIOD_W-1:0] period = '0;
    logic [COLOR_W-1:0]  color = '0;
    logic [COLOR_W-1:0]  fg_color;
    logic [2:0]          fg_alpha;
    logic                busy;
    logic                done;

    alpha_fade_sequencer #(
        .PERIOD_W (PERIOD_W),
        .COLOR_W  (COLOR_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_frame_tick (frame_tick),
        .i_start      (start),
        .i_abort      (abort),
        .i_dir        (dir),
        .i_period     (period),
        .i_color      (color),
        .o_fg_color   (fg_color),
        .o_fg_alpha   (fg_alpha),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: 0 idle, 1 armed, 2 running, 3 done-pulse cycle.
    int                 m_mode  = 0;
    int                 m_k     = 0;
    int                 m_per   = 1;
    bit                 m_dir   = 1'b0;
    logic [COLOR_W-1:0] m_color = '0;
    logic [2:0]         m_alpha = 3'd0;
    bit                 m_done  = 1'b0;

    // Alpha after s completed periods, given the direction latched at start.
    function automatic logic [2:0] ref_alpha(input bit d, input int s);
        int up;
        if (PINGPONG) begin
            up = s % 14;
            if (up > 7) up = 14 - up;
        end else begin
            up = (s > 7) ? 7 : s;
        end
        return d ? 3'(7 - up) : 3'(up);
    endfunction

    function automatic logic [COLOR_W+4:0] expected();
        return {m_color, m_alpha, (m_mode == 1 || m_mode == 2), m_done};
    endfunction

    function automatic logic [COLOR_W+4:0] observed();
        return {fg_color, fg_alpha, busy, done};
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_k     = 0;
        m_per   = 1;
        m_dir   = 1'b0;
        m_color = '0;
        m_alpha = 3'd0;
        m_done  = 1'b0;
    endtask

    // One clock cycle: drive at negedge, let the edge pass, advance the model.
    task automatic cyc(input bit st, input bit ab, input bit tk, input bit d,
                       input int p, input logic [COLOR_W-1:0] c);
        int s;
        @(negedge clk);
        start      = st;
        abort      = ab;
        frame_tick = tk;
        dir        = d;
        period     = p[PERIOD_W-1:0];
        color      = c;
        @(posedge clk);
        #1;
        m_done = 1'b0;
        case (m_mode)
            0: if (st && !ab) begin
                m_dir   = d;
                m_per   = (p == 0) ? 1 : p;
                m_color = c;
                m_alpha = d ? 3'd7 : 3'd0;
                m_mode  = 1;
            end
            1: if (ab) m_mode = 0;
               else if (tk) begin
                   m_mode = 2;
                   m_k    = 0;
               end
            2: if (ab) m_mode = 0;
               else if (tk) begin
                   m_k++;
                   s       = m_k / m_per;
                   m_alpha = ref_alpha(m_dir, s);
                   if ((m_k % m_per) == 0 && (s % 7) == 0) begin
                       m_done = 1'b1;
                       if (!PINGPONG) m_mode = 3;
                   end
               end
            default: m_mode = 0;
        endcase
    endtask

    task automatic idle_cyc(input bit tk);
        cyc(1'b0, 1'b0, tk, 1'b0, 0, '0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (observed() !== expected()) begin
            miscompares++;
            $display("FAIL reset_hold got %h exp %h", observed(), expected());
        end
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 12'h3C3);
        for (int i = 0; i < 4; i++) idle_cyc(1'b1);
        vectors++;
        if (fg_alpha !== 3'd3 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_prerun alpha=%0d busy=%b exp alpha=3 busy=1", fg_alpha, busy);
        end
        // Assert reset between edges: outputs must clear without a clock.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (observed() !== expected()) begin
            miscompares++;
            $display("FAIL reset_async got %h exp %h", observed(), expected());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle_cyc(1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL reset_idle_tick got %h exp %h", observed(), expected());
            end
        end
    endtask

    task automatic test_fade_in();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2, 12'hF00);
        vectors++;
        if (observed() !== expected()) begin
            miscompares++;
            $display("FAIL fade_in_start got %h exp %h", observed(), expected());
        end
        for (int t = 1; t <= 15; t++) begin
            idle_cyc(1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL fade_in_tick%0d got %h exp %h", t, observed(), expected());
            end
            idle_cyc(1'b0);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL fade_in_gap%0d got %h exp %h", t, observed(), expected());
            end
        end
        vectors++;
        if (fg_alpha !== 3'd7 || fg_color !== 12'hF00 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL fade_in_end alpha=%0d color=%h busy=%b done=%b exp 7 F00 0 0",
                     fg_alpha, fg_color, busy, done);
        end
    endtask

    task automatic test_fade_out();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 0, 12'h0A5);
        for (int t = 1; t <= 9; t++) begin
            idle_cyc(1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL fade_out_tick%0d got %h exp %h", t, observed(), expected());
            end
        end
    endtask

    task automatic test_start_tick_and_busy_start();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1, 12'h123);
        idle_cyc(1'b1);
        idle_cyc(1'b1);
        vectors++;
        if (fg_alpha !== 3'd1 || observed() !== expected()) begin
            miscompares++;
            $display("FAIL start_tick_arm got %h exp %h", observed(), expected());
        end
        // Start while busy with different settings must be ignored.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 5, 12'hFFF);
        for (int t = 0; t < 8; t++) begin
            idle_cyc(1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL busy_start_t%0d got %h exp %h", t, observed(), expected());
            end
        end
    endtask

    task automatic test_abort();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 12'h0F0);
        for (int t = 0; t < 5; t++) idle_cyc(1'b1);
        vectors++;
        if (fg_alpha !== 3'd4) begin
            miscompares++;
            $display("FAIL abort_setup alpha=%0d exp 4", fg_alpha);
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 3, 12'h00F);
        for (int t = 0; t < 4; t++) begin
            vectors++;
            if (observed() !== expected() || fg_alpha !== 3'd4 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_hold%0d got %h exp %h", t, observed(), expected());
            end
            idle_cyc(1'b1);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1, 12'h00F);
        vectors++;
        if (observed() !== expected() || fg_alpha !== 3'd7 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_restart got %h exp %h", observed(), expected());
        end
        for (int t = 0; t < 10; t++) begin
            idle_cyc(1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL abort_refade%0d got %h exp %h", t, observed(), expected());
            end
        end
    endtask

    task automatic test_pingpong();
        int dones = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 12'h5A5);
        for (int t = 0; t < 31; t++) begin
            idle_cyc(1'b1);
            if (done) dones++;
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL pingpong_t%0d got %h exp %h", t, observed(), expected());
            end
        end
        vectors++;
        if (dones != 4 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pingpong_turns dones=%0d busy=%b exp 4 1", dones, busy);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, '0);
        vectors++;
        if (observed() !== expected()) begin
            miscompares++;
            $display("FAIL pingpong_abort got %h exp %h", observed(), expected());
        end
    endtask

    task automatic test_random();
        bit st, ab, tk, d;
        int p;
        for (int i = 0; i < 800; i++) begin
            st = ($urandom_range(0, 7) == 0) && (m_mode != 3);
            ab = ($urandom_range(0, 39) == 0);
            tk = ($urandom_range(0, 2) == 0);
            d  = 1'($urandom_range(0, 1));
            p  = $urandom_range(0, 3);
            cyc(st, ab, tk, d, p, 12'($urandom));
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL random_c%0d got %h exp %h", i, observed(), expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fade_in();
        test_fade_out();
        test_start_tick_and_busy_start();
        test_abort();
        if (PINGPONG) test_pingpong();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_alpha_fade_sequencer
